uart_rx_fifo: RTL and testbench

Parametrised UART receiver with integrated receive FIFO: configurable oversampling, 5–9 data bits, five parity modes, 1 or 2 stop bits, per-character error flags stored alongside data, break handling, false-start rejection and a character-timeout indication. It sits between the UART baud generator and the bus-side register file, replacing the single-entry receiver plus external FIFO pairing.

---
 rtl/uart_rx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with an integrated receive FIFO.
// It oversamples and filters the serial line, then frames 5..9 data bits with
// optional parity and one or two stop bits. Each character is stored with its
// {break, frame, parity} error flags. A timeout flag is raised once the FIFO
// holds data and the line has stayed idle for long enough.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a filtered falling edge
// S_START   | timing to mid start bit; a high sample is a false start
// S_DATA    | shifting in data bits, LSB first
// S_PARITY  | sampling and checking the parity bit
// S_STOP1   | sampling the first stop bit
// S_STOP2   | sampling the second stop bit (two-stop-bit frames only)
// S_PUSH    | one cycle: write the character (or a break entry) to the FIFO
// S_BRKWAIT | after a break, waiting for the line to return high
module uart_rx_fifo #(
    parameter int OVERSAMPLE    = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          baudTick,
    input  logic                          uartRxLine,
    input  logic [7:0]                    controlReg,
    input  logic                          fifoRe,
    input  logic                          clearOverrun,
    output logic [8:0]                    fifoData,
    output logic [2:0]                    fifoFlags,
    output logic                          fifoEmpty,
    output logic                          fifoFull,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          overrunError,
    output logic                          rxTimeout
);

    localparam int TW       = $clog2(OVERSAMPLE);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int TO_LIMIT = TIMEOUT_CHARS * 10 * OVERSAMPLE;
    localparam int TOW      = $clog2(TO_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_BRKWAIT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      sync_q;
    logic            filt, filt_d;
    logic [TW-1:0]   tick_cnt;
    logic [3:0]      bit_cnt;
    logic [3:0]      nbits;
    logic [8:0]      data_q;
    logic [6:0]      cfg_q;
    logic            par_bit, par_err, frm_err, stop1_bit, par_exp;
    logic            start_det, tick_hit, is_break, push, pop, push_ok, in_frame;
    logic [11:0]     entry, head;
    logic [11:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [TOW-1:0]  to_cnt;

    assign nbits     = (cfg_q[2:0] <= 3'd4) ? ({1'b0, cfg_q[2:0]} + 4'd5) : 4'd8;
    assign start_det = (state_q == S_IDLE) && controlReg[7] && filt_d && !filt;
    assign in_frame  = state_q inside {S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2};
    assign tick_hit  = baudTick && in_frame &&
                       ((state_q == S_START) ? (tick_cnt == TW'(OVERSAMPLE / 2 - 1))
                                             : (tick_cnt == TW'(OVERSAMPLE - 1)));
    // A break is an all-zero character whose parity bit (if any) and first stop bit were also low.
    assign is_break  = (data_q == 9'd0) && !(cfg_q[3] && par_bit) && !stop1_bit;
    assign entry     = is_break ? {3'b110, 9'd0} : {1'b0, frm_err, par_err, data_q};
    assign push      = (state_q == S_PUSH);

    // Expected parity bit, computed from the received data bits only.
    always_comb begin
        par_exp = 1'b0;
        case (cfg_q[5:4])
            2'b00:   par_exp = ~^data_q;
            2'b01:   par_exp = ^data_q;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    // Input filter: the level only changes once the line and all three stages agree.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 3'b111;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            filt_d <= filt;
            if (baudTick) begin
                sync_q <= {sync_q[1:0], uartRxLine};
                if (!uartRxLine && sync_q == 3'b000)
                    filt <= 1'b0;
                else if (uartRxLine && sync_q == 3'b111)
                    filt <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; dropping the enable abandons whatever frame is in progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_det) state_d = S_START;
            S_START:   if (tick_hit) state_d = filt ? S_IDLE : S_DATA;
            S_DATA:    if (tick_hit && bit_cnt == nbits - 4'd1)
                           state_d = cfg_q[3] ? S_PARITY : S_STOP1;
            S_PARITY:  if (tick_hit) state_d = S_STOP1;
            S_STOP1:   if (tick_hit) state_d = cfg_q[6] ? S_STOP2 : S_PUSH;
            S_STOP2:   if (tick_hit) state_d = S_PUSH;
            S_PUSH:    state_d = is_break ? S_BRKWAIT : S_IDLE;
            S_BRKWAIT: if (filt) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (!controlReg[7]) state_d = S_IDLE;
    end

    // Frame datapath: latch the configuration at start, then count ticks and capture samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            cfg_q     <= '0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            stop1_bit <= 1'b1;
        end else if (start_det) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            cfg_q     <= controlReg[6:0];
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            stop1_bit <= 1'b1;
        end else if (baudTick && in_frame) begin
            tick_cnt <= tick_hit ? '0 : tick_cnt + TW'(1);
            if (tick_hit) begin
                case (state_q)
                    S_DATA: begin
                        data_q[bit_cnt] <= filt;
                        bit_cnt         <= bit_cnt + 4'd1;
                    end
                    S_PARITY: begin
                        par_bit <= filt;
                        par_err <= (filt != par_exp);
                    end
                    S_STOP1: begin
                        stop1_bit <= filt;
                        frm_err   <= !filt;
                    end
                    S_STOP2: if (!filt) frm_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign pop       = fifoRe && !fifoEmpty;
    assign push_ok   = push && (!fifoFull || pop);
    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == CW'(FIFO_DEPTH));
    assign head      = mem[rd_ptr];
    assign fifoData  = fifoEmpty ? 9'd0 : head[8:0];
    assign fifoFlags = fifoEmpty ? 3'd0 : head[11:9];

    // FIFO storage, pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifoCount    <= '0;
            overrunError <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      fifoCount <= fifoCount + CW'(1);
            else if (!push_ok && pop) fifoCount <= fifoCount - CW'(1);
            if (push && !push_ok)   overrunError <= 1'b1;
            else if (clearOverrun)  overrunError <= 1'b0;
        end
    end

    // Idle timer: counts ticks while idle with data waiting, saturating at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            to_cnt <= '0;
        else if (fifoEmpty || pop || start_det)
            to_cnt <= '0;
        else if (state_q == S_IDLE && baudTick && to_cnt < TOW'(TO_LIMIT))
            to_cnt <= to_cnt + TOW'(1);
    end

    assign rxTimeout = (to_cnt >= TOW'(TO_LIMIT));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (OVERSAMPLE 16, FIFO_DEPTH 4, TIMEOUT_CHARS 4).
// The stimulus pushes each expected {flags, data} entry into a queue. A monitor pops
// the DUT FIFO whenever auto_pop is set and compares each head against the queue.
module tb_uart_rx_fifo;
    logic       clock = 1'b0;
    logic       reset, baudTick, uartRxLine, fifoRe, clearOverrun;
    logic [7:0] controlReg;
    logic [8:0] fifoData;
    logic [2:0] fifoFlags;
    logic       fifoEmpty, fifoFull, overrunError, rxTimeout;
    logic [2:0] fifoCount;

    int          checks   = 0;
    int          failures = 0;
    logic        auto_pop = 1'b0;
    logic [11:0] exp_q[$];

    uart_rx_fifo #(.OVERSAMPLE(16), .FIFO_DEPTH(4), .TIMEOUT_CHARS(4)) dut (
        .clock(clock), .reset(reset), .baudTick(baudTick), .uartRxLine(uartRxLine),
        .controlReg(controlReg), .fifoRe(fifoRe), .clearOverrun(clearOverrun),
        .fifoData(fifoData), .fifoFlags(fifoFlags), .fifoEmpty(fifoEmpty),
        .fifoFull(fifoFull), .fifoCount(fifoCount), .overrunError(overrunError),
        .rxTimeout(rxTimeout)
    );

    always #5 clock = ~clock;

    // Baud tick: a one-cycle pulse every fourth clock.
    initial begin
        baudTick = 1'b0;
        forever begin
            repeat (3) @(negedge clock) baudTick = 1'b0;
            @(negedge clock) baudTick = 1'b1;
        end
    end

    // Monitor: whenever data is presented and popping is allowed, compare the head and pop it.
    initial begin
        logic [11:0] e;
        fifoRe = 1'b0;
        forever begin
            @(negedge clock);
            if (fifoRe) fifoRe = 1'b0;
            else if (auto_pop && !reset && !fifoEmpty) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got=%h expected no entry", {fifoFlags, fifoData});
                end else begin
                    e = exp_q.pop_front();
                    if ({fifoFlags, fifoData} !== e) begin
                        failures++;
                        $display("FAIL sb_entry got=%h expected=%h", {fifoFlags, fifoData}, e);
                    end
                end
                fifoRe = 1'b1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clock); while (baudTick !== 1'b1);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clock) uartRxLine = b;
        wait_ticks(16);
    endtask

    // pb < 0 means no parity bit; ns is the number of stop bits.
    task automatic send_frame(input logic [8:0] d, input int nb, input int pb,
                              input logic s1, input int ns, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pb >= 0) send_bit(pb[0]);
        send_bit(s1);
        if (ns == 2) send_bit(s2);
        @(negedge clock) uartRxLine = 1'b1;
        wait_ticks(20);
    endtask

    task automatic wait_nonempty(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            if (!fifoEmpty) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            if (fifoEmpty && exp_q.size() == 0 && !fifoRe) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        uartRxLine   = 1'b1;
        controlReg   = 8'h83;
        clearOverrun = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_data",    32'(fifoData), 32'h0);
        chk("rst_flags",   32'(fifoFlags), 32'h0);
        chk("rst_empty",   32'(fifoEmpty), 32'h1);
        chk("rst_full",    32'(fifoFull), 32'h0);
        chk("rst_count",   32'(fifoCount), 32'h0);
        chk("rst_overrun", 32'(overrunError), 32'h0);
        chk("rst_timeout", 32'(rxTimeout), 32'h0);
        reset = 1'b0;
        wait_ticks(10);

        // 8N1 0xA5
        exp_q.push_back({3'b000, 9'h0A5});
        send_frame(9'h0A5, 8, -1, 1'b1, 1, 1'b1);
        wait_nonempty("t1_arrive");
        chk("t1_count", 32'(fifoCount), 32'd1);
        auto_pop = 1'b1;
        wait_drain("t1_drain");

        // 9 data bits, even parity, parity bit sent as 0 (expected 1)
        controlReg = 8'h9C;
        exp_q.push_back({3'b001, 9'h1FF});
        send_frame(9'h1FF, 9, 0, 1'b1, 1, 1'b1);
        wait_drain("t2_drain");

        // 8E2, second stop bit low
        controlReg = 8'hDB;
        exp_q.push_back({3'b010, 9'h03C});
        send_frame(9'h03C, 8, 0, 1'b1, 2, 1'b0);
        wait_drain("t3_drain");

        // 5 data bits, odd parity, correct parity bit
        controlReg = 8'h88;
        exp_q.push_back({3'b000, 9'h013});
        send_frame(9'h013, 5, 0, 1'b1, 1, 1'b1);
        wait_drain("t4_drain");

        // Break: line low for 3 frame times, then a clean 0x55
        controlReg = 8'h83;
        exp_q.push_back({3'b110, 9'h000});
        @(negedge clock) uartRxLine = 1'b0;
        wait_ticks(480);
        @(negedge clock) uartRxLine = 1'b1;
        wait_ticks(20);
        exp_q.push_back({3'b000, 9'h055});
        send_frame(9'h055, 8, -1, 1'b1, 1, 1'b1);
        wait_drain("t5_drain");

        // Overrun: five bytes into a four-entry FIFO without popping
        auto_pop = 1'b0;
        send_frame(9'h011, 8, -1, 1'b1, 1, 1'b1);
        send_frame(9'h022, 8, -1, 1'b1, 1, 1'b1);
        send_frame(9'h033, 8, -1, 1'b1, 1, 1'b1);
        send_frame(9'h044, 8, -1, 1'b1, 1, 1'b1);
        send_frame(9'h055, 8, -1, 1'b1, 1, 1'b1);
        chk("ovr_count",   32'(fifoCount), 32'd4);
        chk("ovr_full",    32'(fifoFull), 32'd1);
        chk("ovr_flag",    32'(overrunError), 32'd1);
        chk("ovr_head",    32'(fifoData), 32'h011);
        @(negedge clock) clearOverrun = 1'b1;
        @(negedge clock) clearOverrun = 1'b0;
        chk("ovr_cleared", 32'(overrunError), 32'd0);
        exp_q.push_back({3'b000, 9'h011});
        exp_q.push_back({3'b000, 9'h022});
        exp_q.push_back({3'b000, 9'h033});
        exp_q.push_back({3'b000, 9'h044});
        auto_pop = 1'b1;
        wait_drain("ovr_drain");
        chk("empty_data",  32'(fifoData), 32'h0);
        chk("empty_flags", 32'(fifoFlags), 32'h0);

        // Four-tick low glitch: false start, nothing stored
        @(negedge clock) uartRxLine = 1'b0;
        wait_ticks(4);
        @(negedge clock) uartRxLine = 1'b1;
        wait_ticks(200);
        chk("glitch_count", 32'(fifoCount), 32'd0);

        // Enable dropped mid-frame: frame discarded
        @(negedge clock) uartRxLine = 1'b0;
        wait_ticks(40);
        @(negedge clock) controlReg = 8'h03;
        repeat (3) @(negedge clock);
        uartRxLine = 1'b1;
        wait_ticks(30);
        controlReg = 8'h83;
        wait_ticks(200);
        chk("disable_count", 32'(fifoCount), 32'd0);

        // Character timeout: limit is 4 x 10 x 16 = 640 ticks
        auto_pop = 1'b0;
        send_frame(9'h05A, 8, -1, 1'b1, 1, 1'b1);
        wait_nonempty("to_arrive");
        wait_ticks(600);
        chk("to_before", 32'(rxTimeout), 32'd0);
        wait_ticks(50);
        chk("to_after", 32'(rxTimeout), 32'd1);
        exp_q.push_back({3'b000, 9'h05A});
        auto_pop = 1'b1;
        wait_drain("to_drain");
        chk("to_cleared", 32'(rxTimeout), 32'd0);

        // Reset in the middle of a frame: nothing pushed
        auto_pop = 1'b0;
        @(negedge clock) uartRxLine = 1'b0;
        wait_ticks(40);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        chk("midrst_empty", 32'(fifoEmpty), 32'd1);
        reset = 1'b0;
        uartRxLine = 1'b1;
        wait_ticks(200);
        chk("midrst_count", 32'(fifoCount), 32'd0);
        auto_pop = 1'b1;
        exp_q.push_back({3'b000, 9'h081});
        send_frame(9'h081, 8, -1, 1'b1, 1, 1'b1);
        wait_drain("midrst_drain");

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
